btn_debounce_ctrl: RTL

Conditions the four raw, active-low push buttons (comer_inc, curar_dec, next, back) before the register bank. Each button is synchronised, debounced by its own state machine, and converted into a one-cycle press pulse, a debounced level and a one-shot long-press pulse. The block sits between the board pins and BancoRegistro. The long-press pulse on any button can drive menu shortcuts.

---
 rtl/btn_debounce_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/btn_debounce_ctrl.sv
// Purpose : synchronise, debounce and decode four active-low push buttons into press/level/long/release.
// Latency : btn_pulse/btn_level rise in the cycle after edge k+1+DB_CYC when raw is first sampled low at edge k.
// Backpr. : none; outputs are one-cycle strobes and a level, there is no ready/handshake.
//
// Ports   : clk          system clock
//           rst          asynchronous active-low reset, clears all state
//           btn_raw      raw pins, active-low (0 = pressed)
//           btn_pulse    one-cycle strobe per accepted press (plus repeats when enabled)
//           btn_level    debounced level, 1 = pressed
//           btn_long     one-cycle strobe once per hold reaching LONG_MS
//           btn_release  one-cycle strobe per accepted release
// Options : define BTN_REPEAT_EN to add auto-repeat of btn_pulse while a button stays held
//           (parameters REPEAT_DELAY_MS and REPEAT_MS).

module btn_debounce_ctrl #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int LONG_MS         = 3000,
`ifdef BTN_REPEAT_EN
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_MS       = 150,
`endif
  parameter int N_BTN           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_release
);

  localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
  localparam int DB_W     = $clog2(DB_CYC + 1);
  localparam int LONG_W   = $clog2(LONG_CYC + 1);

  // The IDLE/PRESSED sample that enters a wait state is the first stable sample,
  // so the wait state needs DB_CYC-1 further samples: it fires when cnt holds DB_CYC-2.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 2);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYC);
  localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYC - 2);

`ifdef BTN_REPEAT_EN
  localparam int RPT_DLY_CYC = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RPT_CYC     = CLK_HZ / 1000 * REPEAT_MS;
  localparam int RPT_W       = $clog2(RPT_CYC + 1);
  // First repeat is keyed off the hold counter, so the delay must not exceed LONG_MS.
  localparam logic [LONG_W-1:0] RPT_DLY_PRE = LONG_W'(RPT_DLY_CYC - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST    = RPT_W'(RPT_CYC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  // Two-flop synchroniser, reset to the released (high) level.
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    state_t            state_q;
    logic [DB_W-1:0]   cnt_q;
    logic [LONG_W-1:0] hold_q;
    logic              pulse_q;
    logic              level_q;
    logic              long_q;
    logic              rel_q;
    logic              s;
`ifdef BTN_REPEAT_EN
    logic              rpt_on_q;
    logic [RPT_W-1:0]  rpt_cnt_q;
`endif

    assign s = sync2_q[b];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        hold_q    <= '0;
        pulse_q   <= 1'b0;
        level_q   <= 1'b0;
        long_q    <= 1'b0;
        rel_q     <= 1'b0;
`ifdef BTN_REPEAT_EN
        rpt_on_q  <= 1'b0;
        rpt_cnt_q <= '0;
`endif
      end else begin
        pulse_q <= 1'b0;
        long_q  <= 1'b0;
        rel_q   <= 1'b0;
        unique case (state_q)
          IDLE: begin
            if (!s) begin
              state_q <= PRESS_WAIT;
              cnt_q   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (s) begin
              state_q <= IDLE;
            end else if (cnt_q == DB_LAST) begin
              state_q   <= PRESSED;
              pulse_q   <= 1'b1;
              level_q   <= 1'b1;
              hold_q    <= '0;
`ifdef BTN_REPEAT_EN
              rpt_on_q  <= 1'b0;
              rpt_cnt_q <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PRESSED: begin
            if (s) begin
              // Hold and the repeat schedule freeze while the release is qualified.
              state_q <= REL_WAIT;
              cnt_q   <= '0;
            end else begin
              // Saturation guarantees btn_long fires only once per press.
              if (hold_q != LONG_SAT) begin
                hold_q <= hold_q + 1'b1;
                if (hold_q == LONG_PRE) long_q <= 1'b1;
              end
`ifdef BTN_REPEAT_EN
              if (!rpt_on_q) begin
                if (hold_q == RPT_DLY_PRE) begin
                  pulse_q   <= 1'b1;
                  rpt_on_q  <= 1'b1;
                  rpt_cnt_q <= '0;
                end
              end else if (rpt_cnt_q == RPT_LAST) begin
                pulse_q   <= 1'b1;
                rpt_cnt_q <= '0;
              end else begin
                rpt_cnt_q <= rpt_cnt_q + 1'b1;
              end
`endif
            end
          end
          REL_WAIT: begin
            if (!s) begin
              state_q <= PRESSED;
            end else if (cnt_q == DB_LAST) begin
              state_q <= IDLE;
              level_q <= 1'b0;
              rel_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign btn_pulse[b]   = pulse_q;
    assign btn_level[b]   = level_q;
    assign btn_long[b]    = long_q;
    assign btn_release[b] = rel_q;
  end

endmodule
